// File: rtl/c8_pkt_sched.sv
// Round-robin byte-stream scheduler feeding a 480-bit word packer.
// The packer-facing outputs are registered and trail the state register by one cycle.
module c8_pkt_sched #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BYTES = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           pk_data,
  output logic                 pk_valid,
  output logic                 pk_newpkt,
  output logic [7:0]           pk_src_port,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int NW = $clog2(MAX_BYTES + 1);

  localparam logic [1:0] ARB    = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] PAD    = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  logic [1:0]    state_q,    state_d;
  logic [PW-1:0] rrPtr_q,    rrPtr_d;
  logic [PW-1:0] grant_q,    grant_d;
  logic [NW-1:0] byteCnt_q,  byteCnt_d;
  logic [NW-1:0] padCnt_q,   padCnt_d;
  logic [15:0]   dropCnt_q,  dropCnt_d;
  logic [7:0]    pkData_q,   pkData_d;
  logic          pkValid_q,  pkValid_d;
  logic          pkNewpkt_q, pkNewpkt_d;
  logic [7:0]    srcPort_q,  srcPort_d;

  logic          anyValid;
  logic [PW-1:0] grantIdx;
  logic          curValid;
  logic          curLast;
  logic [7:0]    curData;
  logic [NW-1:0] padRem;

  // First valid requester in the order rrPtr, rrPtr+1, ... with wrap-around.
  always_comb begin
    int idx;
    idx      = 0;
    anyValid = 1'b0;
    grantIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!anyValid && req_valid[PW'(idx)]) begin
        anyValid = 1'b1;
        grantIdx = PW'(idx);
      end
    end
  end

  assign curValid = req_valid[grant_q];
  assign curLast  = req_last[grant_q];
  assign curData  = 8'(req_data >> (8 * grant_q));

  always_comb begin
    req_ready = '0;
    if (state_q == STREAM) req_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    grant_d    = grant_q;
    byteCnt_d  = byteCnt_q;
    padCnt_d   = padCnt_q;
    dropCnt_d  = dropCnt_q;
    srcPort_d  = srcPort_q;
    pkData_d   = 8'h00;
    pkValid_d  = 1'b0;
    pkNewpkt_d = 1'b0;
    padRem     = '0;
    case (state_q)
      ARB: begin
        if (anyValid) begin
          grant_d   = grantIdx;
          srcPort_d = 8'(grantIdx);
          rrPtr_d   = (grantIdx == PW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (curValid) begin
          if (byteCnt_q < NW'(MAX_BYTES)) begin
            pkValid_d = 1'b1;
            pkData_d  = curData;
            byteCnt_d = byteCnt_q + 1'b1;
          end else if (dropCnt_q != 16'hFFFF) begin
            dropCnt_d = dropCnt_q + 16'd1;
          end
          // Pad length counts the final byte only if it was forwarded.
          if (curLast) begin
            padRem   = NW'(MAX_BYTES) - byteCnt_d;
            padCnt_d = (padRem == '0) ? NW'(1) : padRem;
            state_d  = PAD;
          end
        end
      end
      PAD: begin
        if (padCnt_q <= NW'(1)) state_d = FLUSH;
        else                    padCnt_d = padCnt_q - 1'b1;
      end
      FLUSH: begin
        pkNewpkt_d = 1'b1;
        byteCnt_d  = '0;
        state_d    = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB;
      rrPtr_q    <= '0;
      grant_q    <= '0;
      byteCnt_q  <= '0;
      padCnt_q   <= '0;
      dropCnt_q  <= '0;
      pkData_q   <= 8'h00;
      pkValid_q  <= 1'b0;
      pkNewpkt_q <= 1'b0;
      srcPort_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grant_q    <= grant_d;
      byteCnt_q  <= byteCnt_d;
      padCnt_q   <= padCnt_d;
      dropCnt_q  <= dropCnt_d;
      pkData_q   <= pkData_d;
      pkValid_q  <= pkValid_d;
      pkNewpkt_q <= pkNewpkt_d;
      srcPort_q  <= srcPort_d;
    end
  end

  assign pk_data     = pkData_q;
  assign pk_valid    = pkValid_q;
  assign pk_newpkt   = pkNewpkt_q;
  assign pk_src_port = srcPort_q;
  assign drop_cnt    = dropCnt_q;
  assign busy        = (state_q != ARB);

endmodule

// File: tb/tb_c8_pkt_sched.sv
// Directed bench for c8_pkt_sched: each scenario task drives a packet pattern
// and compares the packer-side outputs against hand-derived values.
module tb_c8_pkt_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  pk_data;
  logic        pk_valid;
  logic        pk_newpkt;
  logic [7:0]  pk_src_port;
  logic        busy;
  logic [15:0] drop_cnt;

  int numCompared   = 0;
  int numMismatched = 0;

  c8_pkt_sched #(.NUM_REQ(4), .MAX_BYTES(60)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .pk_data(pk_data), .pk_valid(pk_valid), .pk_newpkt(pk_newpkt),
    .pk_src_port(pk_src_port), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int r, input logic [7:0] b, input logic last);
    req_valid        = '0;
    req_last         = '0;
    req_data         = '0;
    req_valid[r]     = 1'b1;
    req_last[r]      = last;
    req_data[8*r +: 8] = b;
  endtask

  // Runs one packet from requester r (byte i = base + i*step) starting from ARB,
  // optionally stalling before byte stallAt, and observes it through the flush pulse.
  task automatic run_packet(input int r, input int len, input logic [7:0] base,
                            input logic [7:0] step, input int stallAt, input int stallLen,
                            output int src, output int fwd, output int badData,
                            output int pad, output int gotNew,
                            output int stallReady, output int stallValid);
    logic [7:0] b;
    fwd = 0; badData = 0; pad = 0; gotNew = 0; stallReady = 0; stallValid = 0;
    present(r, base, len == 1);
    tick();
    src = int'(pk_src_port);
    for (int i = 0; i < len; i++) begin
      if (i == stallAt) begin
        req_valid = '0;
        for (int s = 0; s < stallLen; s++) begin
          tick();
          if (req_ready[r] === 1'b1) stallReady++;
          if (pk_valid !== 1'b0) stallValid++;
        end
      end
      b = base + 8'(i) * step;
      present(r, b, i == len - 1);
      tick();
      if (pk_valid === 1'b1) begin
        if (pk_data !== 8'(base + 8'(fwd) * step)) badData++;
        fwd++;
      end
    end
    req_valid = '0;
    req_last  = '0;
    for (int c = 0; c < 200 && gotNew == 0; c++) begin
      tick();
      if (pk_newpkt === 1'b1) gotNew = 1;
      else if (pk_valid === 1'b0 && pk_data === 8'h00) pad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    tick(); tick();
    numCompared++; if (pk_valid !== 1'b0)   begin numMismatched++; $display("[TB] FAIL reset_pk_valid: got %b expected 0", pk_valid); end
    numCompared++; if (pk_newpkt !== 1'b0)  begin numMismatched++; $display("[TB] FAIL reset_pk_newpkt: got %b expected 0", pk_newpkt); end
    numCompared++; if (pk_data !== 8'h00)   begin numMismatched++; $display("[TB] FAIL reset_pk_data: got %h expected 00", pk_data); end
    numCompared++; if (pk_src_port !== 8'h00) begin numMismatched++; $display("[TB] FAIL reset_src_port: got %h expected 00", pk_src_port); end
    numCompared++; if (req_ready !== 4'b0000) begin numMismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    numCompared++; if (busy !== 1'b0)       begin numMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    numCompared++; if (drop_cnt !== 16'h0)  begin numMismatched++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    rst = 1'b1;
    tick();
    numCompared++; if (busy !== 1'b0) begin numMismatched++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_short_packet();
    int src, fwd, bad, pad, gotNew, sr, sv;
    run_packet(1, 3, 8'hAA, 8'h11, -1, 0, src, fwd, bad, pad, gotNew, sr, sv);
    numCompared++; if (src != 1)     begin numMismatched++; $display("[TB] FAIL short_src: got %0d expected 1", src); end
    numCompared++; if (fwd != 3)     begin numMismatched++; $display("[TB] FAIL short_fwd: got %0d expected 3", fwd); end
    numCompared++; if (bad != 0)     begin numMismatched++; $display("[TB] FAIL short_data: got %0d bad bytes expected 0", bad); end
    numCompared++; if (pad != 57)    begin numMismatched++; $display("[TB] FAIL short_pad: got %0d expected 57", pad); end
    numCompared++; if (gotNew != 1)  begin numMismatched++; $display("[TB] FAIL short_newpkt: got %0d expected 1", gotNew); end
    numCompared++; if (drop_cnt !== 16'd0) begin numMismatched++; $display("[TB] FAIL short_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    int src, fwd, bad, pad, gotNew, sr, sv;
    run_packet(0, 64, 8'h00, 8'h01, -1, 0, src, fwd, bad, pad, gotNew, sr, sv);
    numCompared++; if (src != 0)     begin numMismatched++; $display("[TB] FAIL ovf_src: got %0d expected 0", src); end
    numCompared++; if (fwd != 60)    begin numMismatched++; $display("[TB] FAIL ovf_fwd: got %0d expected 60", fwd); end
    numCompared++; if (bad != 0)     begin numMismatched++; $display("[TB] FAIL ovf_data: got %0d bad bytes expected 0", bad); end
    numCompared++; if (pad != 1)     begin numMismatched++; $display("[TB] FAIL ovf_pad: got %0d expected 1", pad); end
    numCompared++; if (gotNew != 1)  begin numMismatched++; $display("[TB] FAIL ovf_newpkt: got %0d expected 1", gotNew); end
    numCompared++; if (drop_cnt !== 16'd4) begin numMismatched++; $display("[TB] FAIL ovf_drop: got %0d expected 4", drop_cnt); end
  endtask

  task automatic test_exact_fill();
    int src, fwd, bad, pad, gotNew, sr, sv;
    run_packet(3, 60, 8'h80, 8'h03, -1, 0, src, fwd, bad, pad, gotNew, sr, sv);
    numCompared++; if (src != 3)     begin numMismatched++; $display("[TB] FAIL exact_src: got %0d expected 3", src); end
    numCompared++; if (fwd != 60)    begin numMismatched++; $display("[TB] FAIL exact_fwd: got %0d expected 60", fwd); end
    numCompared++; if (bad != 0)     begin numMismatched++; $display("[TB] FAIL exact_data: got %0d bad bytes expected 0", bad); end
    numCompared++; if (pad != 1)     begin numMismatched++; $display("[TB] FAIL exact_pad: got %0d expected 1", pad); end
    numCompared++; if (gotNew != 1)  begin numMismatched++; $display("[TB] FAIL exact_newpkt: got %0d expected 1", gotNew); end
    numCompared++; if (drop_cnt !== 16'd4) begin numMismatched++; $display("[TB] FAIL exact_drop: got %0d expected 4", drop_cnt); end
  endtask

  task automatic test_stall();
    int src, fwd, bad, pad, gotNew, sr, sv;
    run_packet(2, 8, 8'h31, 8'h07, 4, 5, src, fwd, bad, pad, gotNew, sr, sv);
    numCompared++; if (src != 2)     begin numMismatched++; $display("[TB] FAIL stall_src: got %0d expected 2", src); end
    numCompared++; if (sr != 5)      begin numMismatched++; $display("[TB] FAIL stall_ready: got %0d high cycles expected 5", sr); end
    numCompared++; if (sv != 0)      begin numMismatched++; $display("[TB] FAIL stall_valid: got %0d valid cycles expected 0", sv); end
    numCompared++; if (fwd != 8)     begin numMismatched++; $display("[TB] FAIL stall_fwd: got %0d expected 8", fwd); end
    numCompared++; if (bad != 0)     begin numMismatched++; $display("[TB] FAIL stall_data: got %0d bad bytes expected 0", bad); end
    numCompared++; if (pad != 52)    begin numMismatched++; $display("[TB] FAIL stall_pad: got %0d expected 52", pad); end
    numCompared++; if (gotNew != 1)  begin numMismatched++; $display("[TB] FAIL stall_newpkt: got %0d expected 1", gotNew); end
  endtask

  // Every requester always ready with single-byte packets; grants must rotate from 0.
  task automatic test_back_to_back();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] bytes [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    int pad, gotNew;
    rst = 1'b0;
    tick();
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
    rst = 1'b1;
    for (int p = 0; p < 5; p++) begin
      tick();
      numCompared++; if (pk_src_port !== 8'(order[p])) begin numMismatched++; $display("[TB] FAIL b2b_grant%0d: got %0d expected %0d", p, pk_src_port, order[p]); end
      tick();
      numCompared++; if (pk_valid !== 1'b1 || pk_data !== bytes[order[p]]) begin numMismatched++; $display("[TB] FAIL b2b_byte%0d: got valid=%b data=%h expected valid=1 data=%h", p, pk_valid, pk_data, bytes[order[p]]); end
      pad = 0; gotNew = 0;
      for (int c = 0; c < 200 && gotNew == 0; c++) begin
        tick();
        if (pk_newpkt === 1'b1) gotNew = 1;
        else if (pk_valid === 1'b0 && pk_data === 8'h00) pad++;
      end
      numCompared++; if (pad != 59)   begin numMismatched++; $display("[TB] FAIL b2b_pad%0d: got %0d expected 59", p, pad); end
      numCompared++; if (gotNew != 1) begin numMismatched++; $display("[TB] FAIL b2b_newpkt%0d: got %0d expected 1", p, gotNew); end
    end
    req_valid = '0;
    req_last  = '0;
    tick();
  endtask

  task automatic test_reset_midpacket();
    int fwd;
    fwd = 0;
    present(2, 8'h50, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      present(2, 8'h50 + 8'(i), 1'b0);
      tick();
      if (pk_valid === 1'b1) fwd++;
    end
    numCompared++; if (fwd != 10) begin numMismatched++; $display("[TB] FAIL mid_fwd: got %0d expected 10", fwd); end
    rst = 1'b0;
    req_valid = 4'b1010;
    req_last  = '0;
    tick();
    numCompared++; if (pk_valid !== 1'b0 || pk_data !== 8'h00 || pk_newpkt !== 1'b0) begin numMismatched++; $display("[TB] FAIL mid_rst_pk: got valid=%b data=%h newpkt=%b expected 0/00/0", pk_valid, pk_data, pk_newpkt); end
    numCompared++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin numMismatched++; $display("[TB] FAIL mid_rst_ctrl: got busy=%b ready=%b expected 0/0000", busy, req_ready); end
    numCompared++; if (pk_src_port !== 8'h00 || drop_cnt !== 16'h0) begin numMismatched++; $display("[TB] FAIL mid_rst_regs: got src=%0d drop=%0d expected 0/0", pk_src_port, drop_cnt); end
    rst = 1'b1;
    tick();
    numCompared++; if (pk_src_port !== 8'd1) begin numMismatched++; $display("[TB] FAIL mid_regrant: got %0d expected 1", pk_src_port); end
    numCompared++; if (req_ready !== 4'b0010) begin numMismatched++; $display("[TB] FAIL mid_ready: got %b expected 0010", req_ready); end
    numCompared++; if (pk_newpkt !== 1'b0) begin numMismatched++; $display("[TB] FAIL mid_no_newpkt: got %b expected 0", pk_newpkt); end
    req_valid = '0;
  endtask

  initial begin
    $display("[TB] starting c8_pkt_sched directed tests");
    test_reset();
    test_short_packet();
    test_overflow();
    test_exact_fill();
    test_stall();
    test_back_to_back();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
